// File: rtl/alu_issue_unit.sv
// Integer ALU issue unit: accepts an instruction plus operands, drives an external
// combinational ALU from registers, and returns the captured result with rd.
module alu_issue_unit #(
   parameter int unsigned WORDSIZE = 64
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic [31:0]         req_instr,
   input  logic [WORDSIZE-1:0] req_rs1_val,
   input  logic [WORDSIZE-1:0] req_rs2_val,
   output logic [WORDSIZE-1:0] alu_input_a,
   output logic [WORDSIZE-1:0] alu_input_b,
   output logic [9:0]          alu_operation,
   input  logic [WORDSIZE-1:0] alu_out,
   input  logic                alu_overflow,
   output logic                resp_valid,
   input  logic                resp_ready,
   output logic [WORDSIZE-1:0] resp_result,
   output logic                resp_overflow,
   output logic [4:0]          resp_rd,
   output logic                resp_illegal,
   output logic [15:0]         issued_count
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_e;

   state_e              state_q;
   logic                req_ready_q;
   logic                illegal_q;
   logic                resp_valid_q;
   logic                resp_overflow_q;
   logic [WORDSIZE-1:0] a_q;
   logic [WORDSIZE-1:0] b_q;
   logic [WORDSIZE-1:0] result_q;
   logic [9:0]          op_q;
   logic [4:0]          rd_q;
   logic [15:0]         issued_q;
   logic [15:0]         issued_d;

   logic [6:0]          opcode;
   logic [2:0]          funct3;
   logic [6:0]          funct7;
   logic                dec_illegal;
   logic [9:0]          dec_op;
   logic [WORDSIZE-1:0] dec_a;
   logic [WORDSIZE-1:0] dec_b;
   logic                unused_rs1_field;

   assign opcode           = req_instr[6:0];
   assign funct3           = req_instr[14:12];
   assign funct7           = req_instr[31:25];
   assign unused_rs1_field = ^req_instr[19:15];

   always_comb begin
      dec_illegal = 1'b1;
      dec_op      = '0;
      dec_a       = '0;
      dec_b       = '0;
      if (opcode == 7'b0110011 && funct3 == 3'b000 &&
          (funct7 == 7'b0000000 || funct7 == 7'b0100000)) begin
         dec_illegal = 1'b0;
         dec_op      = {funct3, funct7};
         dec_a       = req_rs1_val;
         dec_b       = req_rs2_val;
      end else if (opcode == 7'b0010011 && funct3 == 3'b000) begin
         dec_illegal = 1'b0;
         dec_op      = '0;
         dec_a       = req_rs1_val;
         dec_b       = {{(WORDSIZE-12){req_instr[31]}}, req_instr[31:20]};
      end
   end

   assign issued_d = (issued_q == 16'hFFFF) ? issued_q : issued_q + 16'd1;

   // req_ready is registered so it stays low while reset is held and rises on the first edge after.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q         <= IDLE;
         req_ready_q     <= 1'b0;
         illegal_q       <= 1'b0;
         resp_valid_q    <= 1'b0;
         resp_overflow_q <= 1'b0;
         a_q             <= '0;
         b_q             <= '0;
         result_q        <= '0;
         op_q            <= '0;
         rd_q            <= '0;
         issued_q        <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               req_ready_q <= 1'b1;
               if (req_valid && req_ready_q) begin
                  a_q         <= dec_a;
                  b_q         <= dec_b;
                  op_q        <= dec_op;
                  rd_q        <= req_instr[11:7];
                  illegal_q   <= dec_illegal;
                  req_ready_q <= 1'b0;
                  state_q     <= EXEC;
                  if (!dec_illegal) begin
                     issued_q <= issued_d;
                  end
               end
            end
            EXEC: begin
               result_q        <= illegal_q ? '0 : alu_out;
               resp_overflow_q <= illegal_q ? 1'b0 : alu_overflow;
               resp_valid_q    <= 1'b1;
               state_q         <= RESP;
            end
            RESP: begin
               if (resp_ready) begin
                  resp_valid_q <= 1'b0;
                  req_ready_q  <= 1'b1;
                  state_q      <= IDLE;
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign req_ready     = req_ready_q;
   assign alu_input_a   = a_q;
   assign alu_input_b   = b_q;
   assign alu_operation = op_q;
   assign resp_valid    = resp_valid_q;
   assign resp_result   = result_q;
   assign resp_overflow = resp_overflow_q;
   assign resp_rd       = rd_q;
   assign resp_illegal  = illegal_q;
   assign issued_count  = issued_q;

endmodule
